// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-select and sequencer types for the ALU issue front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    // LEGv8 11-bit opcode fields handled by the issue sequencer
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // CBZ only fixes the top 8 bits; the low 3 belong to the immediate
    localparam logic [7:0]  OP_CBZ8 = 8'b10110100;

    // ALU operation select encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_MEM,
        CLS_CBZ,
        CLS_ILLEGAL
    } op_class_t;

    // Where ALU operand B comes from
    typedef enum logic [1:0] {
        BSRC_RM,
        BSRC_IMM,
        BSRC_ZERO
    } bsrc_t;

    typedef struct packed {
        logic [3:0] sel;
        bsrc_t      b_src;
        op_class_t  cls;
    } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode decoder: 11-bit LEGv8 opcode to ALU select, operand-B source and op class.
// Latency: purely combinational.
// Backpressure: none; follows the opcode input.
module alu_op_decode
    import cpu_pkg::*;
(
    input  logic [10:0] opcode,
    output dec_t        dec
);

    // Exact-match R/D formats first; CBZ is a prefix match on the top 8 bits
    always_comb begin
        dec = '{sel: ALU_AND, b_src: BSRC_RM, cls: CLS_ILLEGAL};
        case (opcode)
            OP_ADD:  dec = '{sel: ALU_ADD, b_src: BSRC_RM,  cls: CLS_R};
            OP_SUB:  dec = '{sel: ALU_SUB, b_src: BSRC_RM,  cls: CLS_R};
            OP_AND:  dec = '{sel: ALU_AND, b_src: BSRC_RM,  cls: CLS_R};
            OP_ORR:  dec = '{sel: ALU_OR,  b_src: BSRC_RM,  cls: CLS_R};
            OP_LDUR: dec = '{sel: ALU_ADD, b_src: BSRC_IMM, cls: CLS_MEM};
            OP_STUR: dec = '{sel: ALU_ADD, b_src: BSRC_IMM, cls: CLS_MEM};
            default: begin
                if (opcode[10:3] == OP_CBZ8) begin
                    dec = '{sel: ALU_SUB, b_src: BSRC_ZERO, cls: CLS_CBZ};
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue sequencer: decodes one LEGv8 op, drives the ALU, captures result/zero, hands it on.
// Latency: accept at edge k -> out_valid after edge k+1+ALU_LATENCY; illegal ops after edge k.
// Backpressure: single op in flight; in_ready low from accept until the response is taken.
module alu_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int ALU_LATENCY = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       in_opcode,
    input  logic [DATA_W-1:0] in_rn_data,
    input  logic [DATA_W-1:0] in_rm_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [4:0]        in_rd,
    output logic [3:0]        alu_select,
    output logic [DATA_W-1:0] alu_input1,
    output logic [DATA_W-1:0] alu_input2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [4:0]        out_rd,
    output logic              out_reg_write,
    output logic              out_is_mem,
    output logic              out_branch_taken,
    output logic              out_illegal
);

    // ALU_LATENCY tops out at 7
    localparam int CNT_W = 3;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  count;
    op_class_t         cls_q;
    dec_t              dec;
    logic              issue_ld;
    logic              cap_ld;
    logic              illegal_ld;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    alu_op_decode u_dec (
        .opcode (in_opcode),
        .dec    (dec)
    );

    // Operand steering: CBZ tests Rt against zero, memory ops add the offset
    always_comb begin
        op_a = (dec.cls == CLS_CBZ) ? in_rm_data : in_rn_data;
        op_b = in_rm_data;
        case (dec.b_src)
            BSRC_IMM:  op_b = in_imm;
            BSRC_ZERO: op_b = '0;
            default:   op_b = in_rm_data;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and load strobes; handshake outputs decode straight from state
    always_comb begin
        state_nxt  = state;
        issue_ld   = 1'b0;
        cap_ld     = 1'b0;
        illegal_ld = 1'b0;
        in_ready   = (state == IDLE);
        out_valid  = (state == RESP);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (dec.cls == CLS_ILLEGAL) begin
                        illegal_ld = 1'b1;
                        state_nxt  = RESP;
                    end else begin
                        issue_ld  = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count == '0) begin
                    cap_ld    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: ALU drive, latency counter and response capture; all hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_select       <= '0;
            alu_input1       <= '0;
            alu_input2       <= '0;
            count            <= '0;
            cls_q            <= CLS_R;
            out_result       <= '0;
            out_zero         <= 1'b0;
            out_rd           <= '0;
            out_reg_write    <= 1'b0;
            out_is_mem       <= 1'b0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
        end else begin
            if (issue_ld) begin
                alu_select <= dec.sel;
                alu_input1 <= op_a;
                alu_input2 <= op_b;
                cls_q      <= dec.cls;
                out_rd     <= in_rd;
                count      <= CNT_W'(ALU_LATENCY);
            end else if (state == WAIT && count != '0) begin
                count <= count - 1'b1;
            end

            if (illegal_ld) begin
                out_result       <= '0;
                out_zero         <= 1'b0;
                out_rd           <= in_rd;
                out_reg_write    <= 1'b0;
                out_is_mem       <= 1'b0;
                out_branch_taken <= 1'b0;
                out_illegal      <= 1'b1;
            end

            if (cap_ld) begin
                out_result       <= alu_result;
                out_zero         <= alu_zero;
                out_reg_write    <= (cls_q == CLS_R);
                out_is_mem       <= (cls_q == CLS_MEM);
                out_branch_taken <= (cls_q == CLS_CBZ) && alu_zero;
                out_illegal      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with behavioural ALUs of latency 1 and 3.
// Latency: checked per op as cycles from accept edge to out_valid.
// Backpressure: out_ready held low across a response, then pulsed.
module tb_alu_issue_ctrl;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_valid3;
    logic          in_ready, in_ready3;
    logic [10:0]   in_opcode;
    logic [DW-1:0] in_rn_data, in_rm_data, in_imm;
    logic [4:0]    in_rd;
    logic          out_ready;

    logic [3:0]    alu_select, alu_select3;
    logic [DW-1:0] alu_input1, alu_input2, alu_input1_3, alu_input2_3;
    logic [DW-1:0] alu_result, alu_result3;
    logic          alu_zero, alu_zero3;
    logic          out_valid, out_valid3;
    logic [DW-1:0] out_result, out_result3;
    logic          out_zero, out_zero3;
    logic [4:0]    out_rd, out_rd3;
    logic          out_reg_write, out_reg_write3;
    logic          out_is_mem, out_is_mem3;
    logic          out_branch_taken, out_branch_taken3;
    logic          out_illegal, out_illegal3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(DW), .ALU_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rn_data(in_rn_data), .in_rm_data(in_rm_data), .in_imm(in_imm), .in_rd(in_rd),
        .alu_select(alu_select), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_is_mem(out_is_mem), .out_branch_taken(out_branch_taken), .out_illegal(out_illegal)
    );

    alu_issue_ctrl #(.DATA_W(DW), .ALU_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_opcode(in_opcode),
        .in_rn_data(in_rn_data), .in_rm_data(in_rm_data), .in_imm(in_imm), .in_rd(in_rd),
        .alu_select(alu_select3), .alu_input1(alu_input1_3), .alu_input2(alu_input2_3),
        .alu_result(alu_result3), .alu_zero(alu_zero3),
        .out_valid(out_valid3), .out_ready(out_ready), .out_result(out_result3),
        .out_zero(out_zero3), .out_rd(out_rd3), .out_reg_write(out_reg_write3),
        .out_is_mem(out_is_mem3), .out_branch_taken(out_branch_taken3), .out_illegal(out_illegal3)
    );

    // Behavioural 64-bit ALU
    function automatic logic [DW-1:0] alu_f(input logic [3:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (s)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return '0;
        endcase
    endfunction

    logic [DW-1:0] pipe3 [3];

    always @(posedge clk) begin
        alu_result <= alu_f(alu_select, alu_input1, alu_input2);
        pipe3[0]   <= alu_f(alu_select3, alu_input1_3, alu_input2_3);
        pipe3[1]   <= pipe3[0];
        pipe3[2]   <= pipe3[1];
    end

    assign alu_zero    = (alu_result == '0);
    assign alu_result3 = pipe3[2];
    assign alu_zero3   = (alu_result3 == '0);

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [10:0]   opcode;
        logic [DW-1:0] rn, rm, imm;
        logic [4:0]    rd;
        logic [3:0]    sel;
        logic [DW-1:0] in1, in2, res;
        logic          zero, rw, mem, bt, ill;
        int            lat;
    } vec_t;

    vec_t vecs[12];

    // Offer one op on the latency-1 DUT and wait (bounded) for its response
    task automatic issue1(input vec_t v, output int lat);
        in_opcode  = v.opcode;
        in_rn_data = v.rn;
        in_rm_data = v.rm;
        in_imm     = v.imm;
        in_rd      = v.rd;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int  lat;
        logic seen;
        vec_t v;

        //          opcode          rn            rm      imm                     rd sel    in1           in2                     res           z  rw mem bt ill lat
        vecs[0]  = '{11'b10001011000, 64'd5,       64'd7,  64'd0,                  5'd3, 4'b0010, 64'd5,     64'd7,                  64'd12,       1'b0,1'b1,1'b0,1'b0,1'b0,3};
        vecs[1]  = '{11'b11001011000, 64'd100,     64'd1,  64'd0,                  5'd4, 4'b0110, 64'd100,   64'd1,                  64'd99,       1'b0,1'b1,1'b0,1'b0,1'b0,3};
        vecs[2]  = '{11'b10001010000, 64'hF0F0,    64'h0FF0, 64'd0,                5'd5, 4'b0000, 64'hF0F0,  64'h0FF0,               64'h00F0,     1'b0,1'b1,1'b0,1'b0,1'b0,3};
        vecs[3]  = '{11'b10101010000, 64'hF000,    64'h000F, 64'd0,                5'd6, 4'b0001, 64'hF000,  64'h000F,               64'hF00F,     1'b0,1'b1,1'b0,1'b0,1'b0,3};
        vecs[4]  = '{11'b10001010000, 64'hF0,      64'h0F, 64'd0,                  5'd9, 4'b0000, 64'hF0,    64'h0F,                 64'd0,        1'b1,1'b1,1'b0,1'b0,1'b0,3};
        vecs[5]  = '{11'b10110100101, 64'h55,      64'd0,  64'd0,                  5'd7, 4'b0110, 64'd0,     64'd0,                  64'd0,        1'b1,1'b0,1'b0,1'b1,1'b0,3};
        vecs[6]  = '{11'b10110100000, 64'h55,      64'd3,  64'd0,                  5'd8, 4'b0110, 64'd3,     64'd0,                  64'd3,        1'b0,1'b0,1'b0,1'b0,1'b0,3};
        vecs[7]  = '{11'b11111000010, 64'h1000,    64'h999, 64'hFFFF_FFFF_FFFF_FFF8, 5'd10, 4'b0010, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFF8,     1'b0,1'b0,1'b1,1'b0,1'b0,3};
        vecs[8]  = '{11'b11111000000, 64'h20,      64'h7,  64'h10,                 5'd11, 4'b0010, 64'h20,   64'h10,                 64'h30,       1'b0,1'b0,1'b1,1'b0,1'b0,3};
        vecs[9]  = '{11'b00000000000, 64'h1,       64'h2,  64'h3,                  5'd12, 4'b0010, 64'h20,   64'h10,                 64'd0,        1'b0,1'b0,1'b0,1'b0,1'b1,1};
        vecs[10] = '{11'b11111111111, 64'h4,       64'h5,  64'h6,                  5'd13, 4'b0010, 64'h20,   64'h10,                 64'd0,        1'b0,1'b0,1'b0,1'b0,1'b1,1};
        vecs[11] = '{11'b10001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,       5'd31, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,      64'd0,        1'b1,1'b1,1'b0,1'b0,1'b0,3};

        rst = 1'b1; in_valid = 1'b0; in_valid3 = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_rn_data = '0; in_rm_data = '0; in_imm = '0; in_rd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_in_ready",   in_ready,   1);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags",  {out_zero, out_reg_write, out_is_mem, out_branch_taken, out_illegal}, 0);
        chk("rst_out_rd",     out_rd,     0);
        chk("rst_alu_select", alu_select, 0);
        chk("rst_alu_in1",    alu_input1, 0);
        chk("rst_alu_in2",    alu_input2, 0);

        // Table of single ops, consumer always ready
        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            issue1(v, lat);
            chk($sformatf("v%0d_latency", i), lat, v.lat);
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_alu_select", i), alu_select, v.sel);
            chk($sformatf("v%0d_alu_in1", i), alu_input1, v.in1);
            chk($sformatf("v%0d_alu_in2", i), alu_input2, v.in2);
            chk($sformatf("v%0d_result", i), out_result, v.res);
            chk($sformatf("v%0d_flags", i), {out_zero, out_reg_write, out_is_mem, out_branch_taken, out_illegal},
                {v.zero, v.rw, v.mem, v.bt, v.ill});
            if (!v.ill) chk($sformatf("v%0d_rd", i), out_rd, v.rd);
            chk($sformatf("v%0d_busy", i), in_ready, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_drain_valid", i), out_valid, 0);
        end

        // Backpressure: SUB 9-9 held for 5 cycles
        out_ready = 1'b0;
        v = '{11'b11001011000, 64'd9, 64'd9, 64'd0, 5'd14, 4'b0110, 64'd9, 64'd9, 64'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,3};
        issue1(v, lat);
        chk("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid_%0d", i),  out_valid,  1);
            chk($sformatf("bp_result_%0d", i), out_result, 0);
            chk($sformatf("bp_zero_%0d", i),   out_zero,   1);
            chk($sformatf("bp_rd_%0d", i),     out_rd,     5'd14);
            chk($sformatf("bp_inrdy_%0d", i),  in_ready,   0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("bp_valid_last", out_valid, 1);
        @(posedge clk); #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_inrdy", in_ready,  1);

        // Reset during WAIT of an ORR: op must vanish
        in_opcode = 11'b10101010000; in_rn_data = 64'h1; in_rm_data = 64'h2; in_rd = 5'd15;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rstmid_in_wait", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_inrdy", in_ready,  1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rstmid_no_resp", seen, 0);

        // Latency-3 DUT running the basic ADD
        in_opcode = 11'b10001011000; in_rn_data = 64'd5; in_rm_data = 64'd7; in_imm = '0; in_rd = 5'd3;
        chk("l3_in_ready", in_ready3, 1);
        in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        lat = 1;
        while (!out_valid3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("l3_latency",  lat, 5);
        chk("l3_select",   alu_select3, 4'b0010);
        chk("l3_result",   out_result3, 64'd12);
        chk("l3_flags",    {out_zero3, out_reg_write3, out_is_mem3, out_branch_taken3, out_illegal3}, 5'b01000);
        chk("l3_rd",       out_rd3, 5'd3);
        @(posedge clk); #1;
        chk("l3_drain",    out_valid3, 0);
        chk("l3_in_ready_back", in_ready3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
